hwpe_stream_tcdm_mux_tracked: RTL

Parametrised TCDM multiplexer that funnels NB_IN_CHAN request channels into NB_OUT_CHAN master ports with configurable address and data width.
- Per-output round-robin arbitration.
- Per-output ID FIFO that tracks up to MAX_OUTSTANDING granted-but-unanswered requests, so variable-latency, pipelined slaves route responses correctly.
- Sits between HWPE streamers and the cluster TCDM interconnect.

---
 rtl/hwpe_stream_tcdm_mux_tracked_pkg.sv | 17 +
 rtl/hwpe_stream_tcdm_mux_id_fifo.sv | 65 ++++++
 rtl/hwpe_stream_tcdm_mux_tracked.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/hwpe_stream_tcdm_mux_tracked_pkg.sv
// rtl/hwpe_stream_tcdm_mux_tracked_pkg.sv - shared helpers for the tracked TCDM multiplexer
package hwpe_stream_package;

    localparam int unsigned TCDM_MUX_PERF_CNT_WIDTH = 32;

    // Width of a tcdm_mux_id_t: one bit minimum, so a single-channel group still has a legal ID.
    function automatic int unsigned tcdm_mux_id_width(input int unsigned m);
        return (m <= 1) ? 1 : $clog2(m);
    endfunction

    // M: number of input channels owned by each output port.
    function automatic int unsigned tcdm_mux_chan_per_out(input int unsigned nb_in,
                                                          input int unsigned nb_out);
        return nb_in / nb_out;
    endfunction

endpackage

// File: rtl/hwpe_stream_tcdm_mux_id_fifo.sv
// rtl/hwpe_stream_tcdm_mux_id_fifo.sv - FIFO of granted channel IDs awaiting a response
module hwpe_stream_tcdm_mux_id_fifo
    import hwpe_stream_package::*;
#(
    parameter int unsigned ID_WIDTH = 1,
    parameter int unsigned DEPTH    = 4
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                clear,
    input  logic                push,
    input  logic                pop,
    input  logic [ID_WIDTH-1:0] data_in,
    output logic [ID_WIDTH-1:0] data_out,
    output logic                full,
    output logic                empty
);

    localparam int unsigned PTR_W = tcdm_mux_id_width(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [DEPTH-1:0][ID_WIDTH-1:0] mem_q;
    logic [PTR_W-1:0]               wr_ptr_q;
    logic [PTR_W-1:0]               rd_ptr_q;
    logic [CNT_W-1:0]               count_q;
    logic                           do_push;
    logic                           do_pop;

    assign full     = (count_q == CNT_W'(DEPTH));
    assign empty    = (count_q == '0);
    assign do_push  = push & ~full;
    assign do_pop   = pop & ~empty;
    assign data_out = mem_q[rd_ptr_q];

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= data_in;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (clear) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/hwpe_stream_tcdm_mux_tracked.sv
// rtl/hwpe_stream_tcdm_mux_tracked.sv - round-robin TCDM mux with per-output outstanding-ID tracking
// Optional: HWPE_STREAM_TCDM_MUX_PERF_EN adds per-output handshake/stall counters.
module hwpe_stream_tcdm_mux_tracked
    import hwpe_stream_package::*;
#(
    parameter int unsigned NB_IN_CHAN      = 4,
    parameter int unsigned NB_OUT_CHAN     = 2,
    parameter int unsigned ADDR_WIDTH      = 32,
    parameter int unsigned DATA_WIDTH      = 32,
    parameter int unsigned MAX_OUTSTANDING = 4
) (
    input  logic                                     clk_i,
    input  logic                                     rst_ni,
    input  logic                                     clear_i,
    input  logic [NB_IN_CHAN-1:0]                    in_req_i,
    input  logic [NB_IN_CHAN-1:0][ADDR_WIDTH-1:0]    in_add_i,
    input  logic [NB_IN_CHAN-1:0]                    in_wen_i,
    input  logic [NB_IN_CHAN-1:0][DATA_WIDTH/8-1:0]  in_be_i,
    input  logic [NB_IN_CHAN-1:0][DATA_WIDTH-1:0]    in_data_i,
    output logic [NB_IN_CHAN-1:0]                    in_gnt_o,
    output logic [NB_IN_CHAN-1:0][DATA_WIDTH-1:0]    in_r_data_o,
    output logic [NB_IN_CHAN-1:0]                    in_r_valid_o,
    output logic [NB_OUT_CHAN-1:0]                   out_req_o,
    output logic [NB_OUT_CHAN-1:0][ADDR_WIDTH-1:0]   out_add_o,
    output logic [NB_OUT_CHAN-1:0]                   out_wen_o,
    output logic [NB_OUT_CHAN-1:0][DATA_WIDTH/8-1:0] out_be_o,
    output logic [NB_OUT_CHAN-1:0][DATA_WIDTH-1:0]   out_data_o,
    input  logic [NB_OUT_CHAN-1:0]                   out_gnt_i,
    input  logic [NB_OUT_CHAN-1:0][DATA_WIDTH-1:0]   out_r_data_i,
    input  logic [NB_OUT_CHAN-1:0]                   out_r_valid_i
`ifdef HWPE_STREAM_TCDM_MUX_PERF_EN
    ,
    output logic [NB_OUT_CHAN-1:0][TCDM_MUX_PERF_CNT_WIDTH-1:0] perf_gnt_o,
    output logic [NB_OUT_CHAN-1:0][TCDM_MUX_PERF_CNT_WIDTH-1:0] perf_stall_o
`endif
);

    localparam int unsigned M        = tcdm_mux_chan_per_out(NB_IN_CHAN, NB_OUT_CHAN);
    localparam int unsigned ID_WIDTH = tcdm_mux_id_width(M);
    localparam int unsigned BE_WIDTH = DATA_WIDTH / 8;

    for (genvar i = 0; i < NB_OUT_CHAN; i++) begin : gen_out
        logic [M-1:0]          owned_req;
        logic [M-1:0]          gnt_loc;
        logic [M-1:0]          rvalid_loc;
        logic [ID_WIDTH-1:0]   ptr_q;
        logic [ID_WIDTH-1:0]   ptr_d;
        logic [ID_WIDTH-1:0]   winner;
        logic [ID_WIDTH-1:0]   head;
        logic                  found;
        logic                  any_req;
        logic                  fifo_full;
        logic                  fifo_empty;
        logic                  req;
        logic                  hs;
        logic                  pop;
        logic [ADDR_WIDTH-1:0] sel_add;
        logic                  sel_wen;
        logic [BE_WIDTH-1:0]   sel_be;
        logic [DATA_WIDTH-1:0] sel_data;

        // Input j = k*NB_OUT_CHAN + i is local channel k of this output.
        for (genvar k = 0; k < M; k++) begin : gen_own
            localparam int unsigned J = k * NB_OUT_CHAN + i;
            assign owned_req[k]    = in_req_i[J];
            assign in_gnt_o[J]     = gnt_loc[k];
            assign in_r_valid_o[J] = rvalid_loc[k];
            assign in_r_data_o[J]  = rvalid_loc[k] ? out_r_data_i[i] : '0;
        end

        // First requester at or after the pointer wins; with no requester the pointer itself is selected.
        always_comb begin
            winner = ptr_q;
            found  = 1'b0;
            for (int unsigned o = 0; o < M; o++) begin
                for (int unsigned k = 0; k < M; k++) begin
                    if (!found && owned_req[k] && (((32'(ptr_q) + o) % M) == k)) begin
                        winner = ID_WIDTH'(k);
                        found  = 1'b1;
                    end
                end
            end
        end

        always_comb begin
            sel_add  = '0;
            sel_wen  = 1'b0;
            sel_be   = '0;
            sel_data = '0;
            for (int unsigned k = 0; k < M; k++) begin
                if (ID_WIDTH'(k) == winner) begin
                    sel_add  = in_add_i[k * NB_OUT_CHAN + i];
                    sel_wen  = in_wen_i[k * NB_OUT_CHAN + i];
                    sel_be   = in_be_i[k * NB_OUT_CHAN + i];
                    sel_data = in_data_i[k * NB_OUT_CHAN + i];
                end
            end
        end

        always_comb begin
            gnt_loc    = '0;
            rvalid_loc = '0;
            for (int unsigned k = 0; k < M; k++) begin
                gnt_loc[k]    = hs & (winner == ID_WIDTH'(k));
                rvalid_loc[k] = pop & (head == ID_WIDTH'(k));
            end
        end

        // Full blocks the request from registered state only, so r_valid never reaches req.
        assign any_req = |owned_req;
        assign req     = any_req & ~fifo_full;
        assign hs      = req & out_gnt_i[i];
        assign pop     = out_r_valid_i[i] & ~fifo_empty;
        assign ptr_d   = hs ? ID_WIDTH'((32'(winner) + 1) % M) : ptr_q;

        assign out_req_o[i]  = req;
        assign out_add_o[i]  = sel_add;
        assign out_wen_o[i]  = sel_wen;
        assign out_be_o[i]   = sel_be;
        assign out_data_o[i] = sel_data;

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                ptr_q <= '0;
            end else if (clear_i) begin
                ptr_q <= '0;
            end else begin
                ptr_q <= ptr_d;
            end
        end

        hwpe_stream_tcdm_mux_id_fifo #(
            .ID_WIDTH (ID_WIDTH),
            .DEPTH    (MAX_OUTSTANDING)
        ) i_id_fifo (
            .clk_i    (clk_i),
            .rst_ni   (rst_ni),
            .clear    (clear_i),
            .push     (hs),
            .pop      (pop),
            .data_in  (winner),
            .data_out (head),
            .full     (fifo_full),
            .empty    (fifo_empty)
        );

`ifdef HWPE_STREAM_TCDM_MUX_PERF_EN
        logic [TCDM_MUX_PERF_CNT_WIDTH-1:0] gnt_cnt_q;
        logic [TCDM_MUX_PERF_CNT_WIDTH-1:0] stall_cnt_q;

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                gnt_cnt_q   <= '0;
                stall_cnt_q <= '0;
            end else if (clear_i) begin
                gnt_cnt_q   <= '0;
                stall_cnt_q <= '0;
            end else begin
                if (hs && (gnt_cnt_q != '1)) begin
                    gnt_cnt_q <= gnt_cnt_q + TCDM_MUX_PERF_CNT_WIDTH'(1);
                end
                if (any_req && !hs && (stall_cnt_q != '1)) begin
                    stall_cnt_q <= stall_cnt_q + TCDM_MUX_PERF_CNT_WIDTH'(1);
                end
            end
        end

        assign perf_gnt_o[i]   = gnt_cnt_q;
        assign perf_stall_o[i] = stall_cnt_q;
`endif
    end

endmodule
